// File: rtl/pw_pkg.sv
// Shared definitions for the door-lock password path (checker and stored-code writer).
package pw_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENTER1 = 2'd1,
    ENTER2 = 2'd2
  } pw_state_t;

  localparam logic [3:0]  KEY_MAX_DIGIT = 4'd9;
  localparam int          PW_DIGITS     = 4;
  localparam logic [15:0] DEFAULT_PW    = 16'h1234;

  // The externally visible digit counter is only 3 bits wide; an 8-digit code
  // would need the value 8, so it is shown saturated at 7.
  function automatic logic [2:0] sat_cnt(input logic [3:0] cnt);
    return cnt[3] ? 3'd7 : cnt[2:0];
  endfunction

endpackage

// File: rtl/pw_digit_shift.sv
// Capture buffer for one password entry: keys shift in from the top digit so
// that once the buffer is full the first key sits in digit 0.
module pw_digit_shift #(
  parameter int DIGITS = 4,
  parameter int DW     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 shift_en,
  input  logic [DW-1:0]        din,
  output logic [DIGITS*DW-1:0] data,
  output logic [3:0]           cnt
);

  logic [DW-1:0] digit_reg [DIGITS];
  logic [3:0]    cnt_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      // Each digit takes its upper neighbour on a shift; the top digit takes the new key.
      always_ff @(posedge clk) begin
        if (rst || clr) begin
          digit_reg[gi] <= '0;
        end else if (shift_en) begin
          if (gi == DIGITS - 1) begin
            digit_reg[gi] <= din;
          end else begin
            digit_reg[gi] <= digit_reg[gi+1];
          end
        end
      end
      assign data[gi*DW +: DW] = digit_reg[gi];
    end
  endgenerate

  // Number of digits captured since the last clear.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_reg <= 4'd0;
    end else if (shift_en) begin
      cnt_reg <= cnt_reg + 4'd1;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/pw_program.sv
// Password writer: new code is typed twice, each closed with '#', and is
// committed to PW_B only when both entries match.
module pw_program
  import pw_pkg::*;
#(
  parameter int                      DIGITS     = PW_DIGITS,
  parameter int                      DW         = 4,
  parameter logic [DIGITS*DW-1:0]    DEFAULT_PW = pw_pkg::DEFAULT_PW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DW-1:0]        Key_B,
  input  logic                 key_vld,
  input  logic                 sharp,
  input  logic                 Dip_1,
  input  logic                 C_pw,
  output logic [DIGITS*DW-1:0] PW_B,
  output logic                 busy,
  output logic [2:0]           digit_cnt,
  output logic                 wr_done,
  output logic                 wr_err
);

  localparam int              W       = DIGITS * DW;
  localparam logic [3:0]      FULL    = 4'(DIGITS);
  localparam logic [DW-1:0]   KEY_MAX = DW'(KEY_MAX_DIGIT);

  pw_state_t      state_reg, state_next;
  logic [W-1:0]   pw_reg, pw_next;
  logic           wr_done_reg, wr_done_next;
  logic           wr_err_reg, wr_err_next;
  logic           busy_reg;
  logic [2:0]     digit_cnt_reg;
  logic [3:0]     cnt_view;

  logic           clr_bufs, sh1, sh2;
  logic [W-1:0]   buf1, buf2;
  logic [3:0]     cnt1, cnt2, cnt_act;
  logic           full, digit_ok, match;

  pw_digit_shift #(.DIGITS(DIGITS), .DW(DW)) u_buf1 (
    .clk(clk), .rst(rst), .clr(clr_bufs), .shift_en(sh1),
    .din(Key_B), .data(buf1), .cnt(cnt1)
  );

  pw_digit_shift #(.DIGITS(DIGITS), .DW(DW)) u_buf2 (
    .clk(clk), .rst(rst), .clr(clr_bufs), .shift_en(sh2),
    .din(Key_B), .data(buf2), .cnt(cnt2)
  );

  assign cnt_act  = (state_reg == ENTER2) ? cnt2 : cnt1;
  assign full     = (cnt_act == FULL);
  assign digit_ok = (Key_B <= KEY_MAX);
  assign match    = &(buf1 ~^ buf2);

  // Next-state, buffer control and pulse decisions; sharp outranks key_vld,
  // and dropping Dip_1 outranks everything as a silent abort.
  always_comb begin
    state_next   = state_reg;
    pw_next      = pw_reg;
    wr_done_next = 1'b0;
    wr_err_next  = 1'b0;
    clr_bufs     = 1'b0;
    sh1          = 1'b0;
    sh2          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (sharp && Dip_1 && C_pw) begin
          state_next = ENTER1;
          clr_bufs   = 1'b1;
        end
      end
      ENTER1, ENTER2: begin
        if (!Dip_1) begin
          state_next = IDLE;
          clr_bufs   = 1'b1;
        end else if (sharp) begin
          if (!full) begin
            state_next  = IDLE;
            clr_bufs    = 1'b1;
            wr_err_next = 1'b1;
          end else if (state_reg == ENTER1) begin
            state_next = ENTER2;
          end else begin
            state_next = IDLE;
            clr_bufs   = 1'b1;
            if (match) begin
              pw_next      = buf1;
              wr_done_next = 1'b1;
            end else begin
              wr_err_next = 1'b1;
            end
          end
        end else if (key_vld) begin
          if (full) begin
            state_next  = IDLE;
            clr_bufs    = 1'b1;
            wr_err_next = 1'b1;
          end else if (digit_ok) begin
            sh1 = (state_reg == ENTER1);
            sh2 = (state_reg == ENTER2);
          end
        end
      end
      default: begin
        state_next = IDLE;
        clr_bufs   = 1'b1;
      end
    endcase
  end

  // Count the outside world will see after this edge: the buffer belonging to
  // the next state, including any digit being shifted in now.
  always_comb begin
    cnt_view = 4'd0;
    if (state_next == ENTER1 && !clr_bufs) begin
      cnt_view = cnt1 + {3'b000, sh1};
    end else if (state_next == ENTER2) begin
      cnt_view = cnt2 + {3'b000, sh2};
    end
  end

  // State, stored code and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      pw_reg        <= DEFAULT_PW;
      wr_done_reg   <= 1'b0;
      wr_err_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      digit_cnt_reg <= 3'd0;
    end else begin
      state_reg     <= state_next;
      pw_reg        <= pw_next;
      wr_done_reg   <= wr_done_next;
      wr_err_reg    <= wr_err_next;
      busy_reg      <= (state_next != IDLE);
      digit_cnt_reg <= sat_cnt(cnt_view);
    end
  end

  assign PW_B      = pw_reg;
  assign busy      = busy_reg;
  assign digit_cnt = digit_cnt_reg;
  assign wr_done   = wr_done_reg;
  assign wr_err    = wr_err_reg;

endmodule

// File: tb/tb_pw_program.sv
// Directed bench for pw_program: one table of per-cycle vectors plus a
// hand-written mid-operation reset sequence.
module tb_pw_program;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  Key_B;
  logic        key_vld;
  logic        sharp;
  logic        Dip_1;
  logic        C_pw;
  logic [15:0] PW_B;
  logic        busy;
  logic [2:0]  digit_cnt;
  logic        wr_done;
  logic        wr_err;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        kv;
    logic        sh;
    logic [3:0]  key;
    logic        dip;
    logic        cpw;
    logic        e_busy;
    logic [2:0]  e_cnt;
    logic        e_done;
    logic        e_err;
    logic [15:0] e_pw;
  } vec_t;

  vec_t vecs[$];

  pw_program dut (
    .clk(clk), .rst(rst), .Key_B(Key_B), .key_vld(key_vld), .sharp(sharp),
    .Dip_1(Dip_1), .C_pw(C_pw), .PW_B(PW_B), .busy(busy),
    .digit_cnt(digit_cnt), .wr_done(wr_done), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  task automatic add(input logic kv, input logic sh, input logic [3:0] key,
                     input logic dip, input logic cpw, input logic eb,
                     input logic [2:0] ec, input logic ed, input logic ee,
                     input logic [15:0] epw);
    vec_t v;
    v.kv = kv; v.sh = sh; v.key = key; v.dip = dip; v.cpw = cpw;
    v.e_busy = eb; v.e_cnt = ec; v.e_done = ed; v.e_err = ee; v.e_pw = epw;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int idx, input logic eb,
                         input logic [2:0] ec, input logic ed, input logic ee,
                         input logic [15:0] epw);
    chk({tag, ".busy"},      idx, 32'(busy),      32'(eb));
    chk({tag, ".digit_cnt"}, idx, 32'(digit_cnt), 32'(ec));
    chk({tag, ".wr_done"},   idx, 32'(wr_done),   32'(ed));
    chk({tag, ".wr_err"},    idx, 32'(wr_err),    32'(ee));
    chk({tag, ".PW_B"},      idx, 32'(PW_B),      32'(epw));
    $display("%s step %0d: busy=%0d cnt=%0d done=%0d err=%0d PW_B=%h",
             tag, idx, busy, digit_cnt, wr_done, wr_err, PW_B);
  endtask

  // Drive one cycle of inputs; strobes are released right after the edge.
  task automatic cyc(input logic kv, input logic sh, input logic [3:0] key,
                     input logic dip, input logic cpw);
    key_vld = kv; sharp = sh; Key_B = key; Dip_1 = dip; C_pw = cpw;
    @(posedge clk);
    #1;
    key_vld = 1'b0; sharp = 1'b0;
  endtask

  initial begin
    // Mismatched confirmation: rejected, default code kept.
    add(0,1,0,1,1, 1,0,0,0,16'h1234);
    add(1,0,5,1,1, 1,1,0,0,16'h1234);
    add(1,0,6,1,1, 1,2,0,0,16'h1234);
    add(1,0,7,1,1, 1,3,0,0,16'h1234);
    add(1,0,8,1,1, 1,4,0,0,16'h1234);
    add(0,1,0,1,1, 1,0,0,0,16'h1234);
    add(1,0,5,1,1, 1,1,0,0,16'h1234);
    add(1,0,6,1,1, 1,2,0,0,16'h1234);
    add(1,0,7,1,1, 1,3,0,0,16'h1234);
    add(1,0,9,1,1, 1,4,0,0,16'h1234);
    add(0,1,0,1,1, 0,0,0,1,16'h1234);
    add(0,0,0,1,1, 0,0,0,0,16'h1234);
    // Matching entries: committed as 8765.
    add(0,1,0,1,1, 1,0,0,0,16'h1234);
    add(1,0,5,1,1, 1,1,0,0,16'h1234);
    add(1,0,6,1,1, 1,2,0,0,16'h1234);
    add(1,0,7,1,1, 1,3,0,0,16'h1234);
    add(1,0,8,1,1, 1,4,0,0,16'h1234);
    add(0,1,0,1,1, 1,0,0,0,16'h1234);
    add(1,0,5,1,1, 1,1,0,0,16'h1234);
    add(1,0,6,1,1, 1,2,0,0,16'h1234);
    add(1,0,7,1,1, 1,3,0,0,16'h1234);
    add(1,0,8,1,1, 1,4,0,0,16'h1234);
    add(0,1,0,1,1, 0,0,1,0,16'h8765);
    add(0,0,0,1,1, 0,0,0,0,16'h8765);
    // Short entry closed by '#'.
    add(0,1,0,1,1, 1,0,0,0,16'h8765);
    add(1,0,1,1,1, 1,1,0,0,16'h8765);
    add(1,0,2,1,1, 1,2,0,0,16'h8765);
    add(1,0,3,1,1, 1,3,0,0,16'h8765);
    add(0,1,0,1,1, 0,0,0,1,16'h8765);
    add(0,0,0,1,1, 0,0,0,0,16'h8765);
    // Non-digit key ignored, fifth digit overflows.
    add(0,1,0,1,1, 1,0,0,0,16'h8765);
    add(1,0,1,1,1, 1,1,0,0,16'h8765);
    add(1,0,4'hA,1,1, 1,1,0,0,16'h8765);
    add(1,0,2,1,1, 1,2,0,0,16'h8765);
    add(1,0,3,1,1, 1,3,0,0,16'h8765);
    add(1,0,4,1,1, 1,4,0,0,16'h8765);
    add(1,0,9,1,1, 0,0,0,1,16'h8765);
    add(0,0,0,1,1, 0,0,0,0,16'h8765);
    // Start refused without C_pw or Dip_1; stray key in IDLE ignored.
    add(0,1,0,1,0, 0,0,0,0,16'h8765);
    add(0,1,0,0,1, 0,0,0,0,16'h8765);
    add(1,0,3,1,1, 0,0,0,0,16'h8765);
    // Dip_1 drops during the second entry: silent abort.
    add(0,1,0,1,1, 1,0,0,0,16'h8765);
    add(1,0,1,1,1, 1,1,0,0,16'h8765);
    add(1,0,2,1,1, 1,2,0,0,16'h8765);
    add(1,0,3,1,1, 1,3,0,0,16'h8765);
    add(1,0,4,1,1, 1,4,0,0,16'h8765);
    add(0,1,0,1,1, 1,0,0,0,16'h8765);
    add(1,0,1,1,1, 1,1,0,0,16'h8765);
    add(1,0,2,1,1, 1,2,0,0,16'h8765);
    add(0,0,0,0,1, 0,0,0,0,16'h8765);
    add(0,0,0,0,1, 0,0,0,0,16'h8765);
    // '#' with a key in the same cycle: key dropped; C_pw ignored after entry.
    add(0,1,0,1,1, 1,0,0,0,16'h8765);
    add(1,0,1,1,0, 1,1,0,0,16'h8765);
    add(1,0,2,1,0, 1,2,0,0,16'h8765);
    add(1,0,3,1,0, 1,3,0,0,16'h8765);
    add(1,0,4,1,0, 1,4,0,0,16'h8765);
    add(1,1,9,1,0, 1,0,0,0,16'h8765);
    add(1,0,1,1,0, 1,1,0,0,16'h8765);
    add(1,0,2,1,0, 1,2,0,0,16'h8765);
    add(1,0,3,1,0, 1,3,0,0,16'h8765);
    add(1,0,4,1,0, 1,4,0,0,16'h8765);
    add(0,1,0,1,0, 0,0,1,0,16'h4321);
    add(0,0,0,1,0, 0,0,0,0,16'h4321);

    rst = 1'b1; Key_B = '0; key_vld = 1'b0; sharp = 1'b0; Dip_1 = 1'b0; C_pw = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 0, 0, 16'h1234);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].kv, vecs[i].sh, vecs[i].key, vecs[i].dip, vecs[i].cpw);
      chk_all("vec", i, vecs[i].e_busy, vecs[i].e_cnt, vecs[i].e_done,
              vecs[i].e_err, vecs[i].e_pw);
    end

    // Reset in the middle of the second entry restores the default code.
    cyc(0,1,0,1,1);
    cyc(1,0,1,1,1);
    cyc(1,0,2,1,1);
    cyc(1,0,3,1,1);
    cyc(1,0,4,1,1);
    cyc(0,1,0,1,1);
    cyc(1,0,5,1,1);
    chk_all("pre_rst", 0, 1, 1, 0, 0, 16'h4321);
    rst = 1'b1;
    cyc(0,0,0,1,1);
    rst = 1'b0;
    chk_all("mid_rst", 0, 0, 0, 0, 0, 16'h1234);
    cyc(0,1,0,1,1);
    chk_all("post_rst", 0, 1, 0, 0, 0, 16'h1234);
    cyc(1,0,7,1,1);
    chk_all("post_rst", 1, 1, 1, 0, 0, 16'h1234);
    cyc(0,0,0,0,1);
    chk_all("post_rst", 2, 0, 0, 0, 0, 16'h1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
